multicycle_ctrl: RTL and testbench

- Control-unit FSM of the multicycle CPU; sits directly upstream of the next-PC mux.
- Sequences each instruction through IF/ID/EXE/MEM/WB.
- Drives the PC-select code and PC write enable consumed by the next-PC stage, plus all datapath enables and selects.
- Every instruction completes in 2-5 cycles; a halt opcode freezes the machine until reset.

---
 rtl/multicycle_ctrl.sv | 178 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences IF/ID/EXE/MEM/WB and drives datapath enables/selects.
// Define MULTICYCLE_INSCNT_EN to build the retired-instruction counter on InsCount.
module multicycle_ctrl #(
  parameter logic [5:0] OP_HALT = 6'b111111,
  parameter int         CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic [1:0]       PCSrc,
  output logic             PCWre,
  output logic             IRWre,
  output logic             RegWre,
  output logic [1:0]       RegDst,
  output logic             WrRegDSrc,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic             ExtSel,
  output logic [2:0]       ALUOp,
  output logic             mRD,
  output logic             mWR,
  output logic             DBDataSrc,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] InsCount
);

  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_LD  = 4'b0100,
    S_EXE_BR = 4'b0101,
    S_EXE_AL = 4'b0110,
    S_WB_AL  = 4'b0111,
    S_HALT   = 4'b1000
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;

  state_t cur, nxt;

  logic is_halt, is_sw, is_lw, is_beq, is_bne, is_j, is_jr, is_jal;
  logic is_alu, is_sub, is_addi, is_or, is_and, is_ori, is_sll, is_slt;

  assign is_halt = (opcode == OP_HALT);
  assign is_sw   = (opcode == OP_SW);
  assign is_lw   = (opcode == OP_LW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_bne  = (opcode == OP_BNE);
  assign is_j    = (opcode == OP_J);
  assign is_jr   = (opcode == OP_JR);
  assign is_jal  = (opcode == OP_JAL);
  assign is_sub  = (opcode == OP_SUB);
  assign is_addi = (opcode == OP_ADDI);
  assign is_or   = (opcode == OP_OR);
  assign is_and  = (opcode == OP_AND);
  assign is_ori  = (opcode == OP_ORI);
  assign is_sll  = (opcode == OP_SLL);
  assign is_slt  = (opcode == OP_SLT);
  assign is_alu  = (opcode == OP_ADD) | is_sub | is_addi | is_or | is_and
                 | is_ori | is_sll | is_slt;

  always_ff @(posedge CLK) begin
    if (Reset) cur <= S_IF;
    else       cur <= nxt;
  end

  // Halt takes priority in ID so a parameterised OP_HALT can shadow a listed opcode.
  always_comb begin
    nxt = S_IF;
    case (cur)
      S_IF: nxt = S_ID;
      S_ID: begin
        if (is_halt)              nxt = S_HALT;
        else if (is_beq | is_bne) nxt = S_EXE_BR;
        else if (is_lw | is_sw)   nxt = S_EXE_LS;
        else if (is_alu)          nxt = S_EXE_AL;
        else                      nxt = S_IF;
      end
      S_EXE_AL: nxt = S_WB_AL;
      S_WB_AL:  nxt = S_IF;
      S_EXE_BR: nxt = S_IF;
      S_EXE_LS: nxt = S_MEM;
      S_MEM:    nxt = is_lw ? S_WB_LD : S_IF;
      S_WB_LD:  nxt = S_IF;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_IF;
    endcase
  end

  always_comb begin
    PCWre  = 1'b0;
    IRWre  = 1'b0;
    RegWre = 1'b0;
    mRD    = 1'b0;
    mWR    = 1'b0;
    PCSrc  = 2'd0;
    case (cur)
      S_IF: IRWre = 1'b1;
      S_ID: begin
        // Jumps and unrecognised opcodes retire here.
        if (!is_halt && !is_alu && !is_beq && !is_bne && !is_lw && !is_sw) begin
          PCWre  = 1'b1;
          RegWre = is_jal;
        end
      end
      S_EXE_BR: PCWre = 1'b1;
      S_MEM: begin
        mRD   = is_lw;
        mWR   = is_sw;
        PCWre = is_sw;
      end
      S_WB_AL, S_WB_LD: begin
        PCWre  = 1'b1;
        RegWre = 1'b1;
      end
      default: ;
    endcase

    if ((is_beq & zero) | (is_bne & ~zero)) PCSrc = 2'd1;
    else if (is_jr)                         PCSrc = 2'd2;
    else if (is_j | is_jal)                 PCSrc = 2'd3;

    if (Reset) begin
      PCWre  = 1'b0;
      IRWre  = 1'b0;
      RegWre = 1'b0;
      mRD    = 1'b0;
      mWR    = 1'b0;
      PCSrc  = 2'd0;
    end
  end

  always_comb begin
    RegDst    = is_jal ? 2'b00 : ((is_addi | is_ori | is_lw) ? 2'b01 : 2'b10);
    WrRegDSrc = ~is_jal;
    DBDataSrc = is_lw;
    ALUSrcA   = is_sll;
    ALUSrcB   = is_addi | is_ori | is_lw | is_sw;
    ExtSel    = ~is_ori;
    ALUOp     = 3'b000;
    if (is_sub | is_beq | is_bne) ALUOp = 3'b001;
    else if (is_sll)              ALUOp = 3'b010;
    else if (is_or | is_ori)      ALUOp = 3'b011;
    else if (is_and)              ALUOp = 3'b100;
    else if (is_slt)              ALUOp = 3'b101;
  end

  assign state = cur;

`ifdef MULTICYCLE_INSCNT_EN
  logic [CNT_W-1:0] ins_cnt;
  always_ff @(posedge CLK) begin
    if (Reset)      ins_cnt <= '0;
    else if (PCWre) ins_cnt <= ins_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end
  assign InsCount = ins_cnt;
`else
  assign InsCount = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised instruction stream checked against a per-instruction-class behavioural model.
module tb_multicycle_ctrl;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic        zero = 1'b0;
  logic [1:0]  PCSrc;
  logic        PCWre, IRWre, RegWre;
  logic [1:0]  RegDst;
  logic        WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel;
  logic [2:0]  ALUOp;
  logic        mRD, mWR, DBDataSrc;
  logic [3:0]  state;
  logic [31:0] InsCount;

  multicycle_ctrl dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
    .PCSrc(PCSrc), .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre),
    .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc),
    .state(state), .InsCount(InsCount)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  logic [5:0] known [15] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                             6'b010010, 6'b011000, 6'b100110, 6'b110000, 6'b110001,
                             6'b110100, 6'b110101, 6'b111000, 6'b111001, 6'b111010};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // 0 jump/nop, 1 branch, 2 alu, 3 sw, 4 lw, 5 halt
  function automatic int cls(input logic [5:0] op);
    case (op)
      6'b111111: return 5;
      6'b110100, 6'b110101: return 1;
      6'b110000: return 3;
      6'b110001: return 4;
      6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
      6'b010010, 6'b011000, 6'b100110: return 2;
      default: return 0;
    endcase
  endfunction

  // {RegDst, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel, ALUOp, DBDataSrc}
  function automatic logic [9:0] sel_exp(input logic [5:0] op);
    logic [1:0] rd;
    logic [2:0] aop;
    rd = (op == 6'b111010) ? 2'b00 :
         (op == 6'b000010 || op == 6'b010010 || op == 6'b110001) ? 2'b01 : 2'b10;
    case (op)
      6'b000001, 6'b110100, 6'b110101: aop = 3'b001;
      6'b011000:                       aop = 3'b010;
      6'b010000, 6'b010010:            aop = 3'b011;
      6'b010001:                       aop = 3'b100;
      6'b100110:                       aop = 3'b101;
      default:                         aop = 3'b000;
    endcase
    return {rd, op != 6'b111010, op == 6'b011000,
            op == 6'b000010 || op == 6'b010010 || op == 6'b110001 || op == 6'b110000,
            op != 6'b010010, aop, op == 6'b110001};
  endfunction

  function automatic logic [1:0] pcsrc_exp(input logic [5:0] op, input logic z);
    if ((op == 6'b110100 && z) || (op == 6'b110101 && !z)) return 2'd1;
    if (op == 6'b111001) return 2'd2;
    if (op == 6'b111000 || op == 6'b111010) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [31:0] cnt_exp();
`ifdef MULTICYCLE_INSCNT_EN
    return exp_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      Reset = 1'b1; opcode = 6'($urandom); zero = 1'($urandom_range(0, 1));
      #1;
      chk("rst_en", {PCWre, IRWre, RegWre, mRD, mWR}, 5'b0);
      chk("rst_pcsrc", PCSrc, 2'd0);
    end
    @(posedge CLK); #1;
    Reset = 1'b0;
    chk("rst_state", state, 4'b0000);
    exp_cnt = 0;
  endtask

  // abort_at >= 0 asserts Reset during that cycle of the instruction
  task automatic run_insn(input logic [5:0] op, input logic bz, input int abort_at);
    logic [3:0] seq [$];
    int c;
    logic last;
    c = cls(op);
    case (c)
      1: seq = '{4'b0000, 4'b0001, 4'b0101};
      2: seq = '{4'b0000, 4'b0001, 4'b0110, 4'b0111};
      3: seq = '{4'b0000, 4'b0001, 4'b0010, 4'b0011};
      4: seq = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100};
      default: seq = '{4'b0000, 4'b0001};
    endcase
    for (int k = 0; k < seq.size(); k++) begin
      @(negedge CLK);
      opcode = op;
      zero = (seq[k] == 4'b0101) ? bz : 1'($urandom_range(0, 1));
      #1;
      if (k == abort_at) begin
        Reset = 1'b1;
        #1;
        chk("abort_state", state, seq[k]);
        chk("abort_en", {PCWre, IRWre, RegWre, mRD, mWR}, 5'b0);
        chk("abort_pcsrc", PCSrc, 2'd0);
        @(posedge CLK); #1;
        Reset = 1'b0;
        chk("abort_to_if", state, 4'b0000);
        exp_cnt = 0;
        return;
      end
      last = (k == seq.size() - 1);
      chk("state", state, seq[k]);
      chk("IRWre", IRWre, k == 0);
      chk("PCWre", PCWre, last);
      chk("RegWre", RegWre, last && (c == 2 || c == 4 || op == 6'b111010));
      chk("mRD", mRD, c == 4 && k == 3);
      chk("mWR", mWR, c == 3 && k == 3);
      if (k == 0) chk("InsCount", InsCount, cnt_exp());
      if (k == 1) chk("selects", {RegDst, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel, ALUOp, DBDataSrc},
                      sel_exp(op));
      if (last) chk("PCSrc", PCSrc, pcsrc_exp(op, zero));
    end
    exp_cnt++;
  endtask

  task automatic run_halt();
    @(negedge CLK); opcode = 6'b111111; #1;
    chk("halt_if", {state, IRWre}, {4'b0000, 1'b1});
    @(negedge CLK); #1;
    chk("halt_id", {state, PCWre}, {4'b0001, 1'b0});
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); zero = 1'($urandom_range(0, 1)); #1;
      chk("halt_state", state, 4'b1000);
      chk("halt_en", {PCWre, IRWre, RegWre, mRD, mWR}, 5'b0);
    end
  endtask

  initial begin
    logic [5:0] op;
    int idx;
    do_reset(2);
    // directed: add, lw, beq(z=1) then j; InsCount seen at the next IF
    run_insn(6'b000000, 1'b0, -1);
    run_insn(6'b110001, 1'b0, -1);
    run_insn(6'b110100, 1'b1, -1);
    run_insn(6'b111000, 1'b0, -1);
    run_insn(6'b110100, 1'b0, -1);
    run_insn(6'b110101, 1'b0, -1);
    run_insn(6'b110101, 1'b1, -1);
    run_insn(6'b111010, 1'b0, -1);
    run_insn(6'b111001, 1'b0, -1);
    run_insn(6'b110000, 1'b0, -1);
    run_insn(6'b011000, 1'b0, -1);
    run_insn(6'b010010, 1'b0, -1);
    for (int n = 0; n < 120; n++) begin
      idx = $urandom_range(0, 15);
      if (idx < 15) op = known[idx];
      else begin
        op = 6'($urandom);
        while (cls(op) != 0 || op == 6'b111000 || op == 6'b111001 || op == 6'b111010)
          op = 6'($urandom);
      end
      run_insn(op, 1'($urandom_range(0, 1)), -1);
    end
    run_insn(6'b110000, 1'b0, 3);
    run_insn(6'b110001, 1'b0, 2);
    run_insn(6'b000001, 1'b0, -1);
    run_halt();
    do_reset(1);
    run_insn(6'b000000, 1'b0, -1);
    run_insn(6'b111000, 1'b0, -1);
    @(negedge CLK); #1;
    chk("final_cnt", InsCount, cnt_exp());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
